// File: rtl/weather_sensor_frame_rx_pkg.sv
// Shared frame-format definitions for the weather sensor receiver: header byte,
// FSM states, field positions and reserved-bit masks.
package weather_sensor_frame_rx_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        GET_FLAGS,
        GET_WIND,
        GET_TEMP,
        GET_CSUM
    } frame_state_t;

    localparam int FLAG_TS_BIT  = 0;
    localparam int FLAG_VIS_LSB = 1;
    localparam int FLAG_VIS_MSB = 2;
    localparam int WIND_MSB     = 5;

    localparam logic [7:0] FLAGS_RSV_MASK = 8'hF8;
    localparam logic [7:0] WIND_RSV_MASK  = 8'hC0;

    function automatic logic [7:0] frame_csum(input logic [7:0] flags,
                                              input logic [7:0] wind_b,
                                              input logic [7:0] temp_b);
        return flags ^ wind_b ^ temp_b;
    endfunction

endpackage

// File: rtl/weather_sensor_frame_rx_sat.sv
// Saturating up-counter with synchronous clear; holds at LIMIT.
// Latency: count updates on the edge after en/clr; no backpressure.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/weather_sensor_frame_rx.sv
// Assembles and validates 5-byte weather sensor frames, updating ECSU outputs atomically.
// Latency: outputs/data_valid 1 cycle after CSUM byte; no backpressure, one byte per cycle.
module weather_sensor_frame_rx
    import weather_sensor_frame_rx_pkg::*;
#(
    parameter logic [7:0] HEADER       = HEADER_DEFAULT,
    parameter int         GAP_TIMEOUT  = 16,
    parameter int         STALE_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       thunderstorm,
    output logic [5:0] wind,
    output logic [1:0] visibility,
    output logic [7:0] temperature,
    output logic       data_valid,
    output logic       frame_error,
    output logic       sensor_stale,
    output logic [7:0] error_count
);

    localparam int GAP_W   = $clog2(GAP_TIMEOUT + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

    frame_state_t state, state_nxt;

    logic [7:0]         flags_sh, wind_sh, temp_sh;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STALE_W-1:0] stale_cnt;
    logic               seen_good;
    logic               frame_done, gap_expire, good_frame, bad_frame, fields_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        // An arriving byte always beats an expiring gap timer.
        gap_expire = (state != HUNT) && !rx_valid && (gap_cnt == GAP_LAST);
        case (state)
            HUNT:      if (rx_valid && (rx_byte == HEADER)) state_nxt = GET_FLAGS;
            GET_FLAGS: if (rx_valid) state_nxt = GET_WIND;
            GET_WIND:  if (rx_valid) state_nxt = GET_TEMP;
            GET_TEMP:  if (rx_valid) state_nxt = GET_CSUM;
            GET_CSUM: begin
                if (rx_valid) begin
                    state_nxt  = HUNT;
                    frame_done = 1'b1;
                end
            end
            default:   state_nxt = HUNT;
        endcase
        if (gap_expire) state_nxt = HUNT;
    end

    assign fields_ok  = ((flags_sh & FLAGS_RSV_MASK) == 8'h00) &&
                        ((wind_sh & WIND_RSV_MASK) == 8'h00) &&
                        (frame_csum(flags_sh, wind_sh, temp_sh) == rx_byte);
    assign good_frame = frame_done && fields_ok;
    assign bad_frame  = (frame_done && !fields_ok) || gap_expire;

    always_ff @(posedge CLK) begin
        if (RST || gap_expire) begin
            flags_sh <= '0;
            wind_sh  <= '0;
            temp_sh  <= '0;
        end else if (rx_valid) begin
            case (state)
                GET_FLAGS: flags_sh <= rx_byte;
                GET_WIND:  wind_sh  <= rx_byte;
                GET_TEMP:  temp_sh  <= rx_byte;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            thunderstorm <= 1'b0;
            wind         <= '0;
            visibility   <= '0;
            temperature  <= '0;
            data_valid   <= 1'b0;
            frame_error  <= 1'b0;
            seen_good    <= 1'b0;
        end else begin
            data_valid  <= good_frame;
            frame_error <= bad_frame;
            if (good_frame) begin
                thunderstorm <= flags_sh[FLAG_TS_BIT];
                visibility   <= flags_sh[FLAG_VIS_MSB:FLAG_VIS_LSB];
                wind         <= wind_sh[WIND_MSB:0];
                temperature  <= temp_sh;
                seen_good    <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(GAP_W), .LIMIT(GAP_TIMEOUT)) u_gap_timer (
        .clk   (CLK),
        .rst   (RST),
        .clr   ((state == HUNT) || rx_valid || gap_expire),
        .en    (1'b1),
        .count (gap_cnt)
    );

    sat_counter #(.WIDTH(STALE_W), .LIMIT(STALE_CYCLES)) u_stale_timer (
        .clk   (CLK),
        .rst   (RST),
        .clr   (good_frame),
        .en    (1'b1),
        .count (stale_cnt)
    );

    sat_counter #(.WIDTH(8), .LIMIT(255)) u_error_count (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .en    (bad_frame),
        .count (error_count)
    );

    assign sensor_stale = !seen_good || (stale_cnt == STALE_MAX);

endmodule

// File: doc/weather_sensor_frame_rx.md
Name: weather_sensor_frame_rx

Overview:
- Upstream stage of ECSU. Receives a byte stream from the aircraft weather sensor and assembles fixed 5-byte frames.
- Validates each frame for header, reserved bits and checksum.
- Drives registered thunderstorm, wind, visibility and temperature values directly into ECSU inputs.
- Flags corrupt frames and a stale sensor, so the downstream stage never sees partially updated data.

Parameters:
HEADER, 8'hA5, frame start byte.
GAP_TIMEOUT, 16, max CLK cycles between bytes inside a frame before the frame is aborted.
STALE_CYCLES, 1000, CLK cycles without a good frame before sensor_stale asserts.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  synchronous, active-high reset.
rx_valid  input  1  rx_byte is valid this cycle; one byte is accepted per cycle when high.
rx_byte  input  8  sensor byte.
thunderstorm  output  1  registered thunderstorm flag to ECSU.
wind  output  6  registered wind speed to ECSU, unsigned.
visibility  output  2  registered visibility code to ECSU.
temperature  output  8  registered temperature to ECSU, signed two's complement.
data_valid  output  1  one-cycle pulse when the outputs have just been updated.
frame_error  output  1  one-cycle pulse on a checksum, reserved-bit or gap-timeout error.
sensor_stale  output  1  level; high when no good frame has arrived within STALE_CYCLES.
error_count  output  8  number of frame errors, saturates at 255.

Behaviour:
- Single clock CLK. Reset is synchronous, active-high (RST).
- Frame format: HEADER, FLAGS, WIND, TEMP, CSUM.
  - FLAGS[0] = thunderstorm, FLAGS[2:1] = visibility, FLAGS[7:3] reserved and must be 0.
  - WIND[5:0] = wind, WIND[7:6] must be 0.
  - TEMP is signed 8-bit.
  - CSUM = FLAGS ^ WIND ^ TEMP.
- FSM states: HUNT, GET_FLAGS, GET_WIND, GET_TEMP, GET_CSUM.
  - HUNT: non-header bytes are discarded silently with no error. HEADER -> GET_FLAGS.
  - Each accepted byte advances the FSM by one state. Payload bytes go to shadow registers only; outputs are untouched mid-frame.
  - GET_CSUM with an accepted byte: always -> HUNT.
    - If the checksum matches and reserved bits are zero: on the next edge, load all four outputs from shadow atomically and pulse data_valid for one cycle.
    - Otherwise: pulse frame_error, outputs unchanged.
- Latency: outputs and data_valid appear 1 cycle after the CSUM byte is accepted.
- HEADER value received mid-frame is treated as data; there is no resync.
- Gap timer:
  - Counts idle cycles while the FSM is not in HUNT and resets on each accepted byte.
  - On reaching GAP_TIMEOUT: -> HUNT, pulse frame_error, discard shadow.
  - If rx_valid is high in the same cycle the timer would expire, the byte wins and there is no timeout.
- error_count increments on every frame_error pulse and holds at 255.
- Stale counter:
  - Cleared on every good frame. Counts otherwise and saturates at STALE_CYCLES.
  - sensor_stale = (count == STALE_CYCLES) OR no good frame since reset.
  - sensor_stale deasserts in the same cycle data_valid pulses.
- Reset values: FSM in HUNT; thunderstorm=0, wind=0, visibility=0, temperature=0, data_valid=0, frame_error=0, error_count=0, sensor_stale=1, all counters 0.
- RST asserted mid-frame aborts the frame with no frame_error; the outputs take their reset values.

Decomposition:
- Shared package: HEADER default, frame state enum (HUNT..GET_CSUM), field bit-position constants, reserved-bit masks.
- One natural sub-module, sat_counter (parameterised width/limit, clear, enable, saturate). It is used for the gap timer, the stale timer and error_count.

Test Plan:
- After reset, send A5 03 0C 19 16 -> one cycle after 16: thunderstorm=1, visibility=1, wind=12, temperature=25, data_valid pulse, sensor_stale=0, frame_error=0.
- Send A5 00 05 FB FE (temp -5) -> temperature=-5 (0xFB), wind=5, data_valid pulse. Then A5 00 05 FB 00 -> frame_error pulse, error_count=1, outputs still hold -5/5.
- Send A5 00 45 19 5C (WIND[7:6]!=0, checksum otherwise correct) -> frame_error pulse, outputs unchanged. Garbage bytes 11 22 before A5 -> discarded with no error.
- Send A5 03 and then idle 16 cycles -> frame_error pulse at timeout, FSM in HUNT. A following full good frame is accepted normally.
- After a good frame, idle 1000 cycles -> sensor_stale rises exactly at cycle 1000; the next good frame clears it with data_valid.
- Assert RST after A5 03 0C -> no frame_error, all outputs 0, sensor_stale=1. Then 300 consecutive bad frames -> error_count saturates at 255.
